// File: rtl/guess_entry_controller.sv
// Game sequencer for one Numberle round: keypad digit entry under a cursor, guess hand-off to the
// checker over valid/ready, try counting and win/loss termination.
module guess_entry_controller #(
  parameter int         MAX_TRIES = 6,
  parameter logic [3:0] BLANK     = 4'hF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [3:0]  key_val,
  input  logic        btn_next,
  input  logic        btn_back,
  input  logic        btn_submit,
  input  logic        new_game,
  input  logic        guess_ready,
  input  logic        result_valid,
  input  logic        result_win,
  output logic [15:0] guess,
  output logic [1:0]  cursor,
  output logic        guess_valid,
  output logic [2:0]  try_count,
  output logic        entry_err,
  output logic        game_won,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_SUBMIT,
    S_WAIT,
    S_WON,
    S_LOST
  } state_t;

  localparam logic [2:0]  MAX_TRIES_L = 3'(MAX_TRIES);
  localparam logic [15:0] EMPTY_GUESS = {4{BLANK}};

  state_t      state_q, state_d;
  logic [15:0] guess_q, guess_d;
  logic [1:0]  cursor_q, cursor_d;
  logic        guess_valid_q, guess_valid_d;
  logic [2:0]  try_q, try_d;
  logic        entry_err_q, entry_err_d;
  logic        won_q, won_d;
  logic        over_q, over_d;
  logic        next_q, back_q, submit_q;

  logic        next_rise, back_rise, submit_rise;
  logic [15:0] guess_work;
  logic [2:0]  try_inc;

  function automatic logic has_blank(input logic [15:0] g);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (g[i*4 +: 4] == BLANK) found = 1'b1;
    end
    return found;
  endfunction

  assign next_rise   = btn_next & ~next_q;
  assign back_rise   = btn_back & ~back_q;
  assign submit_rise = btn_submit & ~submit_q;
  assign try_inc     = try_q + 3'd1;

  // NOTE: combinational block uses blocking '=' with every output defaulted first, so no latch
  // is inferred; state registers below use non-blocking '<=' only.
  always_comb begin
    state_d       = state_q;
    guess_d       = guess_q;
    cursor_d      = cursor_q;
    guess_valid_d = guess_valid_q;
    try_d         = try_q;
    entry_err_d   = 1'b0;
    won_d         = won_q;
    over_d        = over_q;
    guess_work    = guess_q;

    case (state_q)
      S_ENTRY: begin
        // Key write lands at the pre-move cursor; blank check sees this cycle's write.
        if (key_valid && key_val <= 4'd9) begin
          guess_work[{cursor_q, 2'b00} +: 4] = key_val;
        end else if (key_valid && key_val == 4'hF) begin
          guess_work[{cursor_q, 2'b00} +: 4] = BLANK;
        end
        guess_d = guess_work;

        if (next_rise && !back_rise) begin
          cursor_d = cursor_q + 2'd1;
        end else if (back_rise && !next_rise) begin
          cursor_d = cursor_q - 2'd1;
        end

        if (submit_rise) begin
          if (has_blank(guess_work)) begin
            entry_err_d = 1'b1;
          end else begin
            state_d       = S_SUBMIT;
            guess_valid_d = 1'b1;
          end
        end
      end

      S_SUBMIT: begin
        if (guess_valid_q && guess_ready) begin
          guess_valid_d = 1'b0;
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        if (result_valid) begin
          try_d = try_inc;
          if (result_win) begin
            state_d = S_WON;
            won_d   = 1'b1;
            over_d  = 1'b1;
          end else if (try_inc == MAX_TRIES_L) begin
            state_d = S_LOST;
            over_d  = 1'b1;
          end else begin
            state_d  = S_ENTRY;
            guess_d  = EMPTY_GUESS;
            cursor_d = 2'd0;
          end
        end
      end

      default: ;  // WON / LOST hold until new_game
    endcase

    if (new_game) begin
      state_d       = S_ENTRY;
      guess_d       = EMPTY_GUESS;
      cursor_d      = 2'd0;
      guess_valid_d = 1'b0;
      try_d         = 3'd0;
      entry_err_d   = 1'b0;
      won_d         = 1'b0;
      over_d        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_ENTRY;
      guess_q       <= EMPTY_GUESS;
      cursor_q      <= 2'd0;
      guess_valid_q <= 1'b0;
      try_q         <= 3'd0;
      entry_err_q   <= 1'b0;
      won_q         <= 1'b0;
      over_q        <= 1'b0;
      next_q        <= 1'b0;
      back_q        <= 1'b0;
      submit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      guess_q       <= guess_d;
      cursor_q      <= cursor_d;
      guess_valid_q <= guess_valid_d;
      try_q         <= try_d;
      entry_err_q   <= entry_err_d;
      won_q         <= won_d;
      over_q        <= over_d;
      next_q        <= btn_next;
      back_q        <= btn_back;
      submit_q      <= btn_submit;
    end
  end

  assign guess       = guess_q;
  assign cursor      = cursor_q;
  assign guess_valid = guess_valid_q;
  assign try_count   = try_q;
  assign entry_err   = entry_err_q;
  assign game_won    = won_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_guess_entry_controller.sv
// Directed bench for guess_entry_controller: entry, cursor wrap, submit handshake, try limit,
// win, new_game and reset recovery, checked against hand-computed values.
module tb_guess_entry_controller;

  logic        clock;
  logic        resetn;
  logic        key_valid;
  logic [3:0]  key_val;
  logic        btn_next, btn_back, btn_submit;
  logic        new_game;
  logic        guess_ready;
  logic        result_valid, result_win;
  logic [15:0] guess;
  logic [1:0]  cursor;
  logic        guess_valid;
  logic [2:0]  try_count;
  logic        entry_err, game_won, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  guess_entry_controller #(.MAX_TRIES(6), .BLANK(4'hF)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .key_valid    (key_valid),
    .key_val      (key_val),
    .btn_next     (btn_next),
    .btn_back     (btn_back),
    .btn_submit   (btn_submit),
    .new_game     (new_game),
    .guess_ready  (guess_ready),
    .result_valid (result_valid),
    .result_win   (result_win),
    .guess        (guess),
    .cursor       (cursor),
    .guess_valid  (guess_valid),
    .try_count    (try_count),
    .entry_err    (entry_err),
    .game_won     (game_won),
    .game_over    (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_key(input logic [3:0] v);
    key_valid = 1'b1;
    key_val   = v;
    tick();
    key_valid = 1'b0;
    key_val   = 4'h0;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    tick();
  endtask

  task automatic press_back();
    btn_back = 1'b1;
    tick();
    btn_back = 1'b0;
    tick();
  endtask

  // Enters 1,2,3 then key 4 together with submit and ready; ends in WAIT.
  task automatic enter_and_submit(input string tag);
    press_key(4'd1); press_next();
    press_key(4'd2); press_next();
    press_key(4'd3); press_next();
    key_valid   = 1'b1;
    key_val     = 4'd4;
    btn_submit  = 1'b1;
    guess_ready = 1'b1;
    tick();
    key_valid  = 1'b0;
    btn_submit = 1'b0;
    check({tag, "_valid_hi"}, 16'(guess_valid), 16'd1);
    check({tag, "_guess"}, guess, 16'h4321);
    tick();
    guess_ready = 1'b0;
    check({tag, "_valid_lo"}, 16'(guess_valid), 16'd0);
  endtask

  task automatic play_guess(input string tag, input logic win);
    enter_and_submit(tag);
    result_valid = 1'b1;
    result_win   = win;
    tick();
    result_valid = 1'b0;
    result_win   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_guess"},  guess,                16'hFFFF);
    check({tag, "_cursor"}, 16'(cursor),          16'd0);
    check({tag, "_try"},    16'(try_count),       16'd0);
    check({tag, "_valid"},  16'(guess_valid),     16'd0);
    check({tag, "_err"},    16'(entry_err),       16'd0);
    check({tag, "_won"},    16'(game_won),        16'd0);
    check({tag, "_over"},   16'(game_over),       16'd0);
  endtask

  initial begin
    resetn = 1'b0; key_valid = 1'b0; key_val = 4'h0;
    btn_next = 1'b0; btn_back = 1'b0; btn_submit = 1'b0;
    new_game = 1'b0; guess_ready = 1'b0; result_valid = 1'b0; result_win = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    resetn = 1'b1;

    // 1: full guess, ready on the first SUBMIT cycle
    press_key(4'd1); press_next();
    press_key(4'd2); press_next();
    press_key(4'd3); press_next();
    press_key(4'd4);
    check("t1_guess", guess, 16'h4321);
    check("t1_cursor", 16'(cursor), 16'd3);
    guess_ready = 1'b1;
    btn_submit  = 1'b1;
    tick();
    check("t1_valid_hi", 16'(guess_valid), 16'd1);
    check("t1_guess_sub", guess, 16'h4321);
    btn_submit = 1'b0;
    tick();
    guess_ready = 1'b0;
    check("t1_valid_lo", 16'(guess_valid), 16'd0);
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    check("t1_try", 16'(try_count), 16'd1);
    check("t1_guess_clr", guess, 16'hFFFF);
    check("t1_cursor_clr", 16'(cursor), 16'd0);

    // 2: submit with blanks, then clear key
    press_key(4'd5); press_next();
    press_key(4'd6); press_next();
    press_key(4'd7);
    check("t2_guess", guess, 16'hF765);
    btn_submit = 1'b1;
    tick();
    check("t2_err_hi", 16'(entry_err), 16'd1);
    check("t2_valid", 16'(guess_valid), 16'd0);
    btn_submit = 1'b0;
    tick();
    check("t2_err_lo", 16'(entry_err), 16'd0);
    check("t2_valid2", 16'(guess_valid), 16'd0);
    press_back();
    check("t2_cursor", 16'(cursor), 16'd1);
    press_key(4'hF);
    check("t2_clear", guess, 16'hF7F5);
    press_key(4'hB);
    check("t2_ignore_b", guess, 16'hF7F5);

    // 3: cursor wrap, simultaneous buttons, key with cursor move
    press_back();
    check("t3_cursor0", 16'(cursor), 16'd0);
    press_back();
    check("t3_wrap3", 16'(cursor), 16'd3);
    btn_next = 1'b1; btn_back = 1'b1;
    tick();
    check("t3_both", 16'(cursor), 16'd3);
    btn_next = 1'b0; btn_back = 1'b0;
    tick();
    key_valid = 1'b1; key_val = 4'd9; btn_next = 1'b1;
    tick();
    key_valid = 1'b0; btn_next = 1'b0;
    check("t3_old_cur", guess, 16'h97F5);
    check("t3_wrap0", 16'(cursor), 16'd0);
    tick();

    // 4: SUBMIT held without ready
    press_next();
    press_key(4'd8);
    check("t4_guess", guess, 16'h9785);
    btn_submit = 1'b1;
    tick();
    check("t4_valid", 16'(guess_valid), 16'd1);
    btn_submit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      key_val   = 4'(i);
      btn_next  = i[0];
      btn_back  = ~i[0];
      tick();
      check("t4_hold_valid", 16'(guess_valid), 16'd1);
      check("t4_hold_guess", guess, 16'h9785);
      check("t4_hold_cursor", 16'(cursor), 16'd1);
    end
    key_valid = 1'b0; btn_next = 1'b0; btn_back = 1'b0;
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("t4_valid_lo", 16'(guess_valid), 16'd0);
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    check("t4_try", 16'(try_count), 16'd2);

    // 5: exhaust tries (3..6), then stray result
    play_guess("t5a", 1'b0);
    check("t5_try3", 16'(try_count), 16'd3);
    play_guess("t5b", 1'b0);
    play_guess("t5c", 1'b0);
    check("t5_try5", 16'(try_count), 16'd5);
    check("t5_over5", 16'(game_over), 16'd0);
    play_guess("t5d", 1'b0);
    check("t5_try6", 16'(try_count), 16'd6);
    check("t5_over", 16'(game_over), 16'd1);
    check("t5_won", 16'(game_won), 16'd0);
    check("t5_guess", guess, 16'h4321);
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    press_key(4'd7);
    check("t5_try_hold", 16'(try_count), 16'd6);
    check("t5_guess_hold", guess, 16'h4321);

    // 6: new_game, win on try 2, reset mid-WAIT
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_reset_values("t6_ng1");
    play_guess("t6a", 1'b0);
    check("t6_try1", 16'(try_count), 16'd1);
    play_guess("t6b", 1'b1);
    check("t6_won", 16'(game_won), 16'd1);
    check("t6_over", 16'(game_over), 16'd1);
    check("t6_try2", 16'(try_count), 16'd2);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_reset_values("t6_ng2");
    enter_and_submit("t6c");
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_reset_values("t6_rst");
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    check("t6_ignore_res", 16'(try_count), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
